// File: rtl/stack_pkg.sv
// Shared types and constants for the stack engine: FSM states, status codes
// and the default stack geometry / memory timeout.
package stack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WR,
    PUSH_UPD,
    POP_RD,
    POP_UPD,
    FIN
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  localparam logic [15:0] DEF_STACK_BASE  = 16'hFFFF;
  localparam logic [15:0] DEF_STACK_LIMIT = 16'hFF00;
  localparam int          DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/stack_wdog.sv
// Memory-handshake watchdog: counts ticks since the last clear and flags
// expiry once TIMEOUT ticks have elapsed; saturates while expired.
module stack_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stack_engine.sv
// Push/pop sequencer for a downward-growing memory stack with an external SP
// register, bounds checking and a memory-handshake timeout.
module stack_engine
  import stack_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = DEF_STACK_BASE,
  parameter logic [15:0] STACK_LIMIT = DEF_STACK_LIMIT,
  parameter int          MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_push,
  input  logic        req_pop,
  input  logic [15:0] push_data,
  output logic [15:0] pop_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  input  logic [15:0] sp_cur,
  output logic [15:0] sp_new,
  output logic        sp_push,
  output logic        sp_pop,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ready
);

  state_t      state, next_state;
  logic [15:0] addr;
  logic [15:0] data;
  logic        waiting;
  logic        expired;
  logic        accept;
  logic        overflow;
  logic        underflow;

  assign waiting   = (state == PUSH_WR) || (state == POP_RD);
  assign accept    = (state == IDLE) && (req_push || req_pop);
  assign overflow  = req_push && (sp_cur == STACK_LIMIT);
  assign underflow = !req_push && req_pop && (sp_cur == STACK_BASE);

  // Counter stays cleared outside the wait states, so it starts at zero on entry.
  stack_wdog #(.TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!waiting),
    .tick    (waiting && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    sp_push    = 1'b0;
    sp_pop     = 1'b0;
    sp_new     = sp_cur;
    unique case (state)
      IDLE: begin
        if (req_push) begin
          next_state = overflow ? FIN : PUSH_WR;
        end else if (req_pop) begin
          next_state = underflow ? FIN : POP_RD;
        end
      end
      PUSH_WR: begin
        mem_we = !expired;
        if (expired)        next_state = FIN;
        else if (mem_ready) next_state = PUSH_UPD;
      end
      PUSH_UPD: begin
        sp_push    = 1'b1;
        sp_new     = addr - 16'd1;
        next_state = FIN;
      end
      POP_RD: begin
        mem_re = !expired;
        if (expired)        next_state = FIN;
        else if (mem_ready) next_state = POP_UPD;
      end
      POP_UPD: begin
        sp_pop     = 1'b1;
        sp_new     = addr;
        next_state = FIN;
      end
      FIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latches, status and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= 16'h0000;
      data     <= 16'h0000;
      err      <= ERR_OK;
      pop_data <= 16'h0000;
    end else begin
      if (accept) begin
        data <= push_data;
        addr <= req_push ? sp_cur : sp_cur + 16'd1;
        if (overflow)       err <= ERR_OVERFLOW;
        else if (underflow) err <= ERR_UNDERFLOW;
        else                err <= ERR_OK;
      end
      if (waiting && expired) begin
        err <= ERR_TIMEOUT;
      end
      if ((state == POP_RD) && !expired && mem_ready) begin
        pop_data <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign mem_addr  = addr;
  assign mem_wdata = data;

endmodule

// File: tb/tb_stack_engine.sv
// Directed self-checking bench for stack_engine: normal push/pop, bounds
// errors, request priority, memory timeout and mid-transaction reset.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_push, req_pop;
  logic [15:0] push_data;
  logic [15:0] pop_data;
  logic        busy, done;
  logic [1:0]  err;
  logic [15:0] sp_cur, sp_new;
  logic        sp_push, sp_pop;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-operation observations collected by run_op.
  int          we_cyc, re_cyc, push_cnt, pop_cnt, both_cnt, follow_viol;
  logic [15:0] wr_addr, wr_data, rd_addr, strobe_new;
  logic [1:0]  done_err;
  logic        seen;

  stack_engine dut (
    .clk       (clk),
    .reset     (reset),
    .req_push  (req_push),
    .req_pop   (req_pop),
    .push_data (push_data),
    .pop_data  (pop_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sp_cur    (sp_cur),
    .sp_new    (sp_new),
    .sp_push   (sp_push),
    .sp_pop    (sp_pop),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, answer the memory after `lat` request cycles with `rd`,
  // mirror SP updates into sp_cur, and stop at the done pulse (bounded).
  task automatic run_op(input logic p, input logic q, input logic [15:0] d,
                        input int lat, input logic [15:0] rd, input logic hold_pop);
    int req_cnt;
    we_cyc = 0; re_cyc = 0; push_cnt = 0; pop_cnt = 0; both_cnt = 0; follow_viol = 0;
    wr_addr = 16'h0; wr_data = 16'h0; rd_addr = 16'h0; strobe_new = 16'h0;
    done_err = 2'b00; seen = 1'b0; req_cnt = 0;
    @(negedge clk);
    req_push = p; req_pop = q; push_data = d;
    @(negedge clk);
    req_push = 1'b0;
    if (!hold_pop) req_pop = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (mem_we) begin we_cyc++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (mem_re) begin re_cyc++; rd_addr = mem_addr; end
      if (sp_push && sp_pop) both_cnt++;
      if (sp_push) begin push_cnt++; strobe_new = sp_new; end
      if (sp_pop) begin pop_cnt++; strobe_new = sp_new; end
      if (!sp_push && !sp_pop && sp_new !== sp_cur) follow_viol++;
      if (done) begin seen = 1'b1; done_err = err; req_pop = 1'b0; end
      mem_ready = 1'b0;
      if (mem_we || mem_re) begin
        if (req_cnt == lat) begin mem_ready = 1'b1; mem_rdata = rd; end
        req_cnt++;
      end
      if (sp_push || sp_pop) sp_cur = sp_new;
      if (!seen) @(negedge clk);
    end
    mem_ready = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("idle_after_done", {busy, done}, 2'b00);
    check("strobe_exclusive", both_cnt, 0);
    check("sp_new_follows", follow_viol, 0);
  endtask

  initial begin
    int dcount;
    reset = 1'b1; req_push = 1'b0; req_pop = 1'b0; push_data = 16'h0;
    sp_cur = 16'hFFFF; mem_rdata = 16'h0; mem_ready = 1'b0;
    #1;
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_mem_strobes", {mem_we, mem_re, sp_push, sp_pop}, 4'b0000);
    check("rst_err", err, 2'b00);
    check("rst_pop_data", pop_data, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_sp_new", sp_new, 16'hFFFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Push 1234 at FFFF, memory ready one cycle late.
    run_op(1'b1, 1'b0, 16'h1234, 1, 16'h0, 1'b0);
    check("push_wr_addr", wr_addr, 16'hFFFF);
    check("push_wr_data", wr_data, 16'h1234);
    check("push_we_cycles", we_cyc, 2);
    check("push_strobes", {push_cnt[7:0], pop_cnt[7:0]}, 16'h0100);
    check("push_sp_new", strobe_new, 16'hFFFE);
    check("push_err", done_err, 2'b00);

    // Pop back from FFFE: reads FFFF.
    run_op(1'b0, 1'b1, 16'h0, 0, 16'h1234, 1'b0);
    check("pop_rd_addr", rd_addr, 16'hFFFF);
    check("pop_re_cycles", re_cyc, 1);
    check("pop_data", pop_data, 16'h1234);
    check("pop_strobes", {push_cnt[7:0], pop_cnt[7:0]}, 16'h0001);
    check("pop_sp_new", strobe_new, 16'hFFFF);
    check("pop_err", done_err, 2'b00);

    // Underflow: pop on empty stack.
    run_op(1'b0, 1'b1, 16'h0, 0, 16'h9999, 1'b0);
    check("udf_err", done_err, 2'b10);
    check("udf_no_mem", we_cyc + re_cyc, 0);
    check("udf_no_sp", push_cnt + pop_cnt, 0);
    check("udf_pop_data", pop_data, 16'h1234);

    // Overflow: push on full stack.
    sp_cur = 16'hFF00;
    run_op(1'b1, 1'b0, 16'h7777, 0, 16'h0, 1'b0);
    check("ovf_err", done_err, 2'b01);
    check("ovf_no_mem", we_cyc + re_cyc, 0);
    check("ovf_no_sp", push_cnt + pop_cnt, 0);
    check("ovf_sp_cur", sp_cur, 16'hFF00);
    sp_cur = 16'hFFFF;

    // Simultaneous push+pop, pop held through the whole push.
    run_op(1'b1, 1'b1, 16'hABCD, 0, 16'h5A5A, 1'b1);
    check("prio_we_cycles", we_cyc, 1);
    check("prio_re_cycles", re_cyc, 0);
    check("prio_wr_data", wr_data, 16'hABCD);
    check("prio_strobes", {push_cnt[7:0], pop_cnt[7:0]}, 16'h0100);
    repeat (3) @(negedge clk);
    check("prio_no_pop_later", {busy, mem_re}, 2'b00);
    check("prio_pop_data", pop_data, 16'h1234);
    check("prio_sp_cur", sp_cur, 16'hFFFE);

    // Push with memory never ready.
    run_op(1'b1, 1'b0, 16'h4444, 1000, 16'h0, 1'b0);
    check("to_push_we_cycles", we_cyc, 16);
    check("to_push_err", done_err, 2'b11);
    check("to_push_no_sp", push_cnt, 0);
    check("to_push_sp_cur", sp_cur, 16'hFFFE);
    check("to_err_held", err, 2'b11);

    // Pop with memory never ready: pop_data must keep its old value.
    run_op(1'b0, 1'b1, 16'h0, 1000, 16'h5555, 1'b0);
    check("to_pop_re_cycles", re_cyc, 16);
    check("to_pop_err", done_err, 2'b11);
    check("to_pop_no_sp", pop_cnt, 0);
    check("to_pop_data", pop_data, 16'h1234);

    // Stray mem_ready while idle.
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("idle_ready_ignored", {busy, done}, 2'b00);
    check("idle_ready_pop_data", pop_data, 16'h1234);
    mem_ready = 1'b0;

    // Reset while in POP_RD.
    sp_cur = 16'hFFFE;
    @(negedge clk);
    req_pop = 1'b1;
    @(negedge clk);
    req_pop = 1'b0;
    check("rpop_re_before", mem_re, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rpop_re_dropped", {mem_re, busy}, 2'b00);
    check("rpop_pop_data", pop_data, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("rpop_no_done", dcount, 0);
    check("rpop_err", err, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
